// File: rtl/mult_res_accumulator_pkg.sv
// Shared constants for the multiplier result accumulator: default widths,
// signedness encoding and a constant-foldable ceiling log2.
package mult_res_accumulator_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ACC_WIDTH  = 24;
  localparam int DEF_BLOCK_LEN  = 4;

  localparam int SIGNED_OFF = 0;
  localparam int SIGNED_ON  = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_res_accumulator.sv
// Sums BLOCK_LEN consecutive multiplier results and presents each block sum,
// sample count and sticky overflow flag through a single holding register.
module mult_res_accumulator
  import mult_res_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int BLOCK_LEN  = DEF_BLOCK_LEN,
  parameter int SIGNED     = SIGNED_OFF,
  localparam int CNT_W     = clog2(BLOCK_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic [CNT_W-1:0]      out_count,
  output logic                  out_ovf,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ovf_acc_q, ovf_acc_d;
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]     out_count_q, out_count_d;
  logic                 out_ovf_q, out_ovf_d;
  logic                 out_valid_q, out_valid_d;

  logic                 last_s, accept_s, fl_s, drain_s, close_s, ovf_step_s;
  logic [ACC_WIDTH-1:0] ext_s, sum_s;
  logic [ACC_WIDTH:0]   sum_full_s;
  logic [CNT_W-1:0]     count_inc_s;

  assign last_s   = (count_q == CNT_W'(BLOCK_LEN - 1));
  // Stall only when the closing sample (or a flush) would need the busy holding register.
  assign in_ready = ~(out_valid_q & ~out_ready & (last_s | flush));
  assign accept_s = in_valid & in_ready;
  assign fl_s     = flush & in_ready;
  assign drain_s  = out_valid_q & out_ready;
  assign close_s  = (accept_s & last_s) | (fl_s & ((count_q != '0) | accept_s));
  assign count_inc_s = count_q + CNT_W'(accept_s);

  // Extend the sample, add it and derive the per-step overflow.
  always_comb begin
    ext_s = '0;
    if (SIGNED == SIGNED_ON) begin
      ext_s = ACC_WIDTH'($signed(in_data));
    end else begin
      ext_s = ACC_WIDTH'(in_data);
    end
    sum_full_s = {1'b0, acc_q} + {1'b0, ext_s};
    if (accept_s) begin
      sum_s = sum_full_s[ACC_WIDTH-1:0];
      if (SIGNED == SIGNED_ON) begin
        ovf_step_s = (acc_q[ACC_WIDTH-1] == ext_s[ACC_WIDTH-1]) &&
                     (sum_full_s[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
      end else begin
        ovf_step_s = sum_full_s[ACC_WIDTH];
      end
    end else begin
      sum_s      = acc_q;
      ovf_step_s = 1'b0;
    end
  end

  // Next-state for the running block and the output holding register.
  always_comb begin
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_acc_d   = ovf_acc_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    if (close_s) begin
      out_data_d  = sum_s;
      out_count_d = count_inc_s;
      out_ovf_d   = ovf_acc_q | ovf_step_s;
      out_valid_d = 1'b1;
      acc_d       = '0;
      count_d     = '0;
      ovf_acc_d   = 1'b0;
    end else begin
      if (accept_s) begin
        acc_d     = sum_s;
        count_d   = count_inc_s;
        ovf_acc_d = ovf_acc_q | ovf_step_s;
      end else begin
        acc_d = acc_q;
      end
      if (drain_s) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      count_q     <= '0;
      ovf_acc_q   <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_acc_q   <= ovf_acc_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;
  assign out_valid = out_valid_q;

endmodule
